// File: rtl/add_chk_pkg.sv
// Shared definitions for the adder vector checker: FSM state encodings,
// vector index width and the operand-B pattern generator.
package add_chk_pkg;

  localparam int IDX_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Rotates the low 'width' bits of idx left by 3, then XORs in the seed.
  // Bits at and above 'width' are left to the caller to discard.
  function automatic logic [IDX_W-1:0] gen_op_b(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] seed,
                                                input int               width);
    logic [IDX_W-1:0] rot;
    logic [3:0]       src;
    int               dst;
    rot = '0;
    src = '0;
    dst = 0;
    for (int b = 0; b < IDX_W; b++) begin
      if (b < width) begin
        src = 4'(b);
        dst = (b + 3) % width;
        rot[dst[3:0]] = idx[src];
      end
    end
    return rot ^ seed;
  endfunction

endpackage

// File: rtl/add_chk_delay.sv
// LAT-stage shift register carrying {valid, expected} from the operand
// register to the compare point; a plain wire when LAT is 0.
module add_chk_delay #(
  parameter int LAT = 1,
  parameter int DW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_vld  = in_vld;
      assign out_data = in_data;
    end else begin : g_shift
      localparam int SW = DW + 1;
      localparam int CW = LAT * SW;

      logic [CW-1:0] chain_q;
      logic [CW-1:0] chain_d;

      // New entry enters at the bottom; the oldest stage falls off the top.
      always_comb begin
        chain_d = CW'({chain_q, in_vld, in_data});
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          chain_q <= '0;
        end else begin
          chain_q <= chain_d;
        end
      end

      assign {out_vld, out_data} = chain_q[CW-1 -: SW];
    end
  endgenerate

endmodule

// File: rtl/add_vector_checker.sv
// Stimulus/check engine for the 8-bit adder pins: drives operand pairs,
// compares the returned sum after LAT cycles. Optional: ADD_CHK_FIRST_FAIL_EN.
module add_vector_checker
  import add_chk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               NUM_VEC = 256,
  parameter int               LAT     = 1,
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(8'hA5),
  parameter int               ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] sum_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
`ifdef ADD_CHK_FIRST_FAIL_EN
  ,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_sum
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VEC - 1);
  localparam logic [2:0]       DRAIN_LAST = 3'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam logic [IDX_W-1:0] SEED_X     = IDX_W'(SEED);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       drain_cnt_q, drain_cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] exp0_q, exp0_d;
  logic             vld0_q, vld0_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0] nxt_idx;
  logic             load_vec;
  logic             start_acc;
  logic             cmp_vld;
  logic [WIDTH-1:0] cmp_exp;
  logic             mismatch;

  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch  = cmp_vld && (sum_in != cmp_exp);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    drain_cnt_d = drain_cnt_q;
    nxt_idx     = '0;
    load_vec    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_DRIVE;
          idx_d    = '0;
          load_vec = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (idx_q == LAST_IDX) begin
          state_d     = (LAT > 0) ? ST_DRAIN : ST_DONE;
          drain_cnt_d = '0;
        end else begin
          nxt_idx  = idx_q + IDX_W'(1);
          idx_d    = nxt_idx;
          load_vec = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 3'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Operands go to zero whenever no vector is being driven.
    op_a_d = load_vec ? WIDTH'(nxt_idx) : '0;
    op_b_d = load_vec ? WIDTH'(gen_op_b(nxt_idx, SEED_X, WIDTH)) : '0;
    exp0_d = op_a_d + op_b_d;
    vld0_d = load_vec;

    err_cnt_d = err_cnt_q;
    if (start_acc) begin
      err_cnt_d = '0;
    end else if (mismatch && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      drain_cnt_q <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      exp0_q      <= '0;
      vld0_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drain_cnt_q <= drain_cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      exp0_q      <= exp0_d;
      vld0_q      <= vld0_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // exp0 is aligned with the operand registers; the delay adds the path latency.
  add_chk_delay #(
    .LAT (LAT),
    .DW  (WIDTH)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (vld0_q),
    .in_data  (exp0_q),
    .out_vld  (cmp_vld),
    .out_data (cmp_exp)
  );

`ifdef ADD_CHK_FIRST_FAIL_EN
  logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
  logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
  logic [WIDTH-1:0] ff_sum_q, ff_sum_d;
  logic             ff_seen_q, ff_seen_d;

  // Compares occur in vector order, so a running count names the vector.
  always_comb begin
    cmp_idx_d = cmp_idx_q;
    ff_idx_d  = ff_idx_q;
    ff_sum_d  = ff_sum_q;
    ff_seen_d = ff_seen_q;
    if (start_acc) begin
      cmp_idx_d = '0;
      ff_idx_d  = '0;
      ff_sum_d  = '0;
      ff_seen_d = 1'b0;
    end else if (cmp_vld) begin
      cmp_idx_d = cmp_idx_q + IDX_W'(1);
      if (mismatch && !ff_seen_q) begin
        ff_idx_d  = cmp_idx_q;
        ff_sum_d  = sum_in;
        ff_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_idx_q <= '0;
      ff_idx_q  <= '0;
      ff_sum_q  <= '0;
      ff_seen_q <= 1'b0;
    end else begin
      cmp_idx_q <= cmp_idx_d;
      ff_idx_q  <= ff_idx_d;
      ff_sum_q  <= ff_sum_d;
      ff_seen_q <= ff_seen_d;
    end
  end

  assign first_fail_idx = ff_idx_q;
  assign first_fail_sum = ff_sum_q;
`endif

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pass      = (state_q == ST_DONE) && (err_cnt_q == '0);
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_add_vector_checker.sv
// Directed bench for add_vector_checker: four instances cover LAT=0 clean/fault,
// error saturation, and latency alignment through two external sum registers.
module tb_add_vector_checker;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic fault_en;

  always #5 clk = ~clk;

  // dut0: NUM_VEC=4, LAT=0, sum from a combinational adder (optionally LSB-flipped)
  // dut1: NUM_VEC=8, LAT=0, ERR_W=2, sum tied to zero
  // dut2: NUM_VEC=4, LAT=2, sum through two registers
  // dut3: NUM_VEC=4, LAT=1, same two-register wiring
  logic [7:0] op_a0, op_b0, sum0, err0;
  logic [7:0] op_a1, op_b1, sum1;
  logic [1:0] err1;
  logic [7:0] op_a2, op_b2, sum2, err2;
  logic [7:0] op_a3, op_b3, sum3, err3;
  logic       busy0, done0, pass0;
  logic       busy1, done1, pass1;
  logic       busy2, done2, pass2;
  logic       busy3, done3, pass3;
  logic [1:0] dbg0, dbg1, dbg2, dbg3;
  logic [7:0] r1_2, r2_2, r1_3, r2_3;
`ifdef ADD_CHK_FIRST_FAIL_EN
  logic [15:0] ffi0, ffi1, ffi2, ffi3;
  logic [7:0]  ffs0, ffs1, ffs2, ffs3;
`endif

  assign sum0 = 8'(op_a0 + op_b0) ^ {7'd0, fault_en};
  assign sum1 = 8'h00;
  assign sum2 = r2_2;
  assign sum3 = r2_3;

  always @(posedge clk) begin
    r1_2 <= 8'(op_a2 + op_b2);
    r2_2 <= r1_2;
    r1_3 <= 8'(op_a3 + op_b3);
    r2_3 <= r1_3;
  end

  add_vector_checker #(.WIDTH(8), .NUM_VEC(4), .LAT(0), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a0), .op_b(op_b0), .sum_in(sum0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .dbg_state(dbg0)
`ifdef ADD_CHK_FIRST_FAIL_EN
    , .first_fail_idx(ffi0), .first_fail_sum(ffs0)
`endif
  );

  add_vector_checker #(.WIDTH(8), .NUM_VEC(8), .LAT(0), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a1), .op_b(op_b1), .sum_in(sum1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .dbg_state(dbg1)
`ifdef ADD_CHK_FIRST_FAIL_EN
    , .first_fail_idx(ffi1), .first_fail_sum(ffs1)
`endif
  );

  add_vector_checker #(.WIDTH(8), .NUM_VEC(4), .LAT(2), .ERR_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a2), .op_b(op_b2), .sum_in(sum2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .dbg_state(dbg2)
`ifdef ADD_CHK_FIRST_FAIL_EN
    , .first_fail_idx(ffi2), .first_fail_sum(ffs2)
`endif
  );

  add_vector_checker #(.WIDTH(8), .NUM_VEC(4), .LAT(1), .ERR_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a3), .op_b(op_b3), .sum_in(sum3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .dbg_state(dbg3)
`ifdef ADD_CHK_FIRST_FAIL_EN
    , .first_fail_idx(ffi3), .first_fail_sum(ffs3)
`endif
  );

  // Scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run on all instances: start in cycle 0, observe cycles 1..9.
  // Expected op pairs: i, rotl(i,3)^A5 -> 00/A5, 01/AD, 02/B5, 03/BD.
  task automatic run_vectors(input logic fault, input int restart_at, input logic [7:0] exp_err0);
    logic [15:0] pair;
    fault_en = fault;
    exp_q = {16'h00A5, 16'h01AD, 16'h02B5, 16'h03BD};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c <= 4) begin
        pair = exp_q.pop_front();
        check("d0_ops", {op_a0, op_b0}, pair);
        check("d0_busy", busy0, 1'b1);
        check("d2_ops", {op_a2, op_b2}, pair);
      end
      if (c == 1) begin
        check("d0_err_clr", err0, 0);
        check("d1_err_clr", err1, 0);
        check("d1_ops0", {op_a1, op_b1}, 16'h00A5);
      end
      if (c == 5) begin
        check("d0_done", done0, 1'b1);
        check("d0_busy_done", busy0, 1'b0);
        check("d0_err", err0, exp_err0);
        check("d0_pass", pass0, exp_err0 == 8'd0);
        check("d0_ops_idle", {op_a0, op_b0}, 16'h0000);
      end
      check("d1_done_t", done1, c >= 9);
      check("d2_done_t", done2, c >= 7);
      check("d3_done_t", done3, c >= 6);
      start = (c == restart_at);
      tick();
    end
    start = 1'b0;
    check("d0_done_hold", done0, 1'b1);
    check("d1_err_sat", err1, 2'd3);
    check("d1_pass", pass1, 1'b0);
    check("d2_err", err2, 0);
    check("d2_pass", pass2, 1'b1);
    check("d3_err", err3, 4);
    check("d3_pass", pass3, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    fault_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_state", dbg0, 2'd0);
    check("rst_ops", {op_a0, op_b0}, 16'h0000);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_pass", pass0, 1'b0);
    check("rst_err", err0, 0);

    // Clean run, then fault-injected restart from DONE
    run_vectors(1'b0, 0, 8'd0);
    run_vectors(1'b1, 0, 8'd4);
`ifdef ADD_CHK_FIRST_FAIL_EN
    check("ff_idx", ffi0, 16'd0);
    check("ff_sum", ffs0, 8'hA4);
`endif

    // Clean restart with a start pulse in the middle of DRIVE
    run_vectors(1'b0, 2, 8'd0);
`ifdef ADD_CHK_FIRST_FAIL_EN
    check("ff_idx_clr", ffi0, 16'd0);
    check("ff_sum_clr", ffs0, 8'h00);
`endif

    // Reset while vector 2 is on the pins, with mismatches already counted
    fault_en = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_ops", {op_a0, op_b0}, 16'h02B5);
    check("mid_err", err0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_state", dbg0, 2'd0);
    check("mrst_ops", {op_a0, op_b0}, 16'h0000);
    check("mrst_err", err0, 0);
    check("mrst_busy", busy0, 1'b0);
    tick();
    tick();
    check("mrst_idle_state", dbg0, 2'd0);
    check("mrst_idle_done", done0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
